// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: STAGES-segment pipelined ripple adder/subtractor with valid/ready flow; define PIPE_ADDER_OVERFLOW_EN to add the OF flag.
module pipelined_carry_adder #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  input  logic                  SUB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF
`ifdef PIPE_ADDER_OVERFLOW_EN
  ,
  output logic                  OF
`endif
);
  localparam int SEG = DATA_WIDTH / STAGES;
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = DATA_WIDTH - k * SEG;
    logic [RW-1:0] a_i, b_i;
    logic c_i, v_i, v_q, c_q;
    logic [SEG:0] r;
    logic [(k+1)*SEG-1:0] s_q, s_n;
    if (k == 0) begin : g_in
      assign a_i = A;
      assign b_i = B ^ {DATA_WIDTH{SUB}};
      assign c_i = SUB | Cin;
      assign v_i = in_valid;
      assign s_n = r[SEG-1:0];
    end else begin : g_in
      assign a_i = g_stage[k-1].g_fwd.a_q;
      assign b_i = g_stage[k-1].g_fwd.b_q;
      assign c_i = g_stage[k-1].c_q;
      assign v_i = g_stage[k-1].v_q;
      assign s_n = {r[SEG-1:0], g_stage[k-1].s_q};
    end
    assign r = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        c_q <= r[SEG];
        s_q <= s_n;
      end
    // only the operand slices still to be added travel forward
    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SEG-1:0] a_q, b_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_i[RW-1:SEG];
          b_q <= b_i[RW-1:SEG];
        end
    end
`ifdef PIPE_ADDER_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_of
      logic of_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) of_q <= 1'b0;
        else if (adv) of_q <= r[SEG] ^ (a_i[SEG-1] ^ b_i[SEG-1] ^ r[SEG-1]);
    end
`endif
  end
  assign out_valid = g_stage[STAGES-1].v_q;
  assign S = g_stage[STAGES-1].s_q;
  assign CF = g_stage[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVERFLOW_EN
  assign OF = g_stage[STAGES-1].g_of.of_q;
`endif
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: scoreboard bench for pipelined_carry_adder (16 bits, 4 stages).
module tb_pipelined_carry_adder;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, Cin = 1'b0, SUB = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, CF;
  logic [W-1:0] A = '0, B = '0, S;
`ifdef PIPE_ADDER_OVERFLOW_EN
  logic OF;
`endif
  int total = 0, bad = 0;
  logic [W+1:0] q[$];
  logic [W+1:0] exp_v;

  pipelined_carry_adder #(.DATA_WIDTH(W), .STAGES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .CF(CF)
`ifdef PIPE_ADDER_OVERFLOW_EN
    , .OF(OF)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic sub);
    logic [W-1:0] be;
    logic [W:0] r;
    be = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sub | c};
    return {(a[W-1] == be[W-1]) && (r[W-1] != a[W-1]), r};
  endfunction

  always @(negedge clk) if (!rst) begin
    if (out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result S=%h CF=%b (none expected)", S, CF);
      end else begin
        exp_v = q.pop_front();
        if ({CF, S} !== exp_v[W:0]) begin
          bad++;
          $display("FAIL result got CF=%b S=%h want CF=%b S=%h", CF, S, exp_v[W], exp_v[W-1:0]);
        end
`ifdef PIPE_ADDER_OVERFLOW_EN
        total++;
        if (OF !== exp_v[W+1]) begin
          bad++;
          $display("FAIL overflow got OF=%b want %b", OF, exp_v[W+1]);
        end
`endif
      end
    end
    if (in_valid && in_ready) q.push_back(model(A, B, Cin, SUB));
  end

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk) #1;
      n++;
    end
    @(posedge clk) #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || S !== '0 || CF !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got ov=%b S=%h CF=%b ir=%b want 0 0000 0 1", out_valid, S, CF, in_ready);
    end
    @(posedge clk) #1;
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[3] = '{16'h1234, 16'hFFFF, 16'h8000};
    logic [W-1:0] vb[3] = '{16'h0FFF, 16'h0001, 16'h0001};
    logic vc[3] = '{1'b1, 1'b0, 1'b0};
    logic vs[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int lat = 1;
      out_ready = 1'b1;
      A = va[i]; B = vb[i]; Cin = vc[i]; SUB = vs[i]; in_valid = 1'b1;
      @(posedge clk) #1;
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
        @(posedge clk) #1;
        lat++;
      end
      total++;
      if (lat != N) begin
        bad++;
        $display("FAIL latency vec%0d got %0d want %0d", i, lat, N);
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); SUB = 1'(i & 1); in_valid = 1'b1;
      @(posedge clk) #1;
    end
    A = 16'hDEAD; B = 16'hBEEF;
    held = q[0][W-1:0];
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== held) begin
        bad++;
        $display("FAIL stall_hold cyc%0d got ov=%b ir=%b S=%h want 1 0 %h", i, out_valid, in_ready, S, held);
      end
      @(posedge clk) #1;
    end
    total++;
    if (q.size() != 4) begin
      bad++;
      $display("FAIL stall_count got %0d queued want 4", q.size());
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); SUB = 1'($urandom);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk) #1;
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      A = W'($urandom) | 16'h0100; B = W'($urandom); Cin = 1'b1; SUB = 1'b0; in_valid = 1'b1;
      @(posedge clk) #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || S !== '0 || CF !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got ov=%b S=%h CF=%b want 0 0000 0", out_valid, S, CF);
    end
    q.delete();
    @(posedge clk) #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stale_after_reset cyc%0d got ov=%b want 0", i, out_valid);
      end
      @(posedge clk) #1;
    end
    A = 16'h00FF; B = 16'h0001; Cin = 1'b0; SUB = 1'b0; in_valid = 1'b1;
    @(posedge clk) #1;
    drain();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
